temporizador_puerta: RTL and testbench
======================================

# temporizador_puerta

Door-dwell timer that answers the elevator state machine's timer requests. It accepts `start_timer` / `restart_timer` commands, counts a programmable dwell interval, and reports completion on `t_expired`. The count is re-armed while the door sensor reports an obstruction and frozen while the overweight sensor is active. It sits beside the controller FSM inside the elevator top level and is the responder end of the FSM's timer handshake.

## Interface
- `DIV`, 50000 — prescaler divisor: clk cycles per timer tick; must be ≥ 2.
- `CNT_W`, 16 — width of the interval and remaining count.
- `DEFAULT_TIME`, 3000 — ticks loaded when `t_load` is 0.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start_timer`  in  1  level-sampled; starts the timer from IDLE or EXPIRED.
- `restart_timer`  in  1  level-sampled; reloads and runs from any state.
- `sensor_puerta`  in  1  1 = door obstructed; reloads the count while running.
- `sensor_sobrepeso`  in  1  1 = overweight; freezes the count.
- `t_load`  in  CNT_W  interval in ticks, sampled on a load.
- `t_expired`  out  1  high while in EXPIRED.
- `busy`  out  1  high in RUN or HOLD.
- `remaining`  out  CNT_W  ticks left.
- `state`  out  2  IDLE=0, RUN=1, HOLD=2, EXPIRED=3.

## Operation
- **Load:** `remaining` ← (`t_load` == 0 ? `DEFAULT_TIME` : `t_load`). The prescaler clears on every load.
- **Command priority**, highest first: `reset` > `restart_timer` > `start_timer` > `sensor_sobrepeso` > `sensor_puerta` > tick.
- **IDLE:**
  - `restart_timer` or `start_timer` → load, go to RUN.
  - Sensors are ignored.
- **RUN:**
  - `restart_timer` → load, stay in RUN.
  - `start_timer` → ignored.
  - `sensor_sobrepeso` → go to HOLD; count and prescaler freeze.
  - `sensor_puerta` → load, stay in RUN.
  - On a tick: if `remaining` == 1, then `remaining` ← 0 and go to EXPIRED; otherwise decrement.
- **HOLD:**
  - `restart_timer` → load, stay in HOLD.
  - `sensor_sobrepeso` deasserted → RUN on the next cycle, resuming from the frozen `remaining` and prescaler value.
  - `sensor_puerta` in HOLD → ignored.
- **EXPIRED:**
  - `t_expired` = 1, `remaining` = 0.
  - `start_timer` or `restart_timer` → load, go to RUN.
  - All other inputs → hold EXPIRED indefinitely.
- **Arithmetic:** all unsigned, CNT_W bits. `remaining` never wraps below 0. A loaded value of 2^CNT_W−1 is legal.
- **Illegal state encoding:** none is reachable. The default branch returns to IDLE.

## Timing
- **Reset values:** `state`=IDLE, `t_expired`=0, `busy`=0, `remaining`=0, prescaler=0.
- **Registered outputs:** all outputs are registered. A command sampled at edge N is visible in cycle N+1.
- **Tick, with prescaler compiled in:** a tick occurs in RUN when the prescaler equals DIV−1; the prescaler then wraps to 0.
- **Expiry latency:** a load at edge N with value L gives `t_expired`=1 first in cycle N+1+L·DIV, or N+1+L when the prescaler is compiled out.
- **Sensor obstruction:** `sensor_puerta` held high keeps `remaining`=L every cycle. Expiry occurs L ticks after its deassertion.
- **Load and tick in the same cycle:** the load wins.
- **Simultaneous sensors:** `sensor_sobrepeso` and `sensor_puerta` both high in RUN → HOLD with no reload.
- **Reset mid-count:** reset takes effect at the next edge regardless of state, including EXPIRED.

## Configuration
- `TEMPORIZADOR_PRESCALER_EN` defined:
  - The prescaler counter is instantiated.
  - One tick every DIV clocks.
- `TEMPORIZADOR_PRESCALER_EN` not defined:
  - No prescaler logic.
  - Every clk cycle in RUN is a tick.
  - DIV is ignored.
  - Used for simulation and short benches.

## Test plan
All scenarios are run with the macro undefined and CNT_W=16 unless noted.
1. **Basic dwell:** reset, then `start_timer` pulse with `t_load`=5 at edge N → `busy`=1 from cycle N+1, `remaining` 5,4,3,2,1, then `t_expired`=1 at N+6, `state`=3, holding until the next command.
2. **Default load:** `start_timer` with `t_load`=0, DEFAULT_TIME=3000 → `remaining`=3000 at N+1 and `t_expired` at N+3001.
3. **Door obstruction:** `t_load`=4; assert `sensor_puerta` at `remaining`=2 for 3 cycles → `remaining` stays 4, then counts down, and `t_expired` comes 4 cycles after deassertion.
4. **Overweight freeze:**
   - `t_load`=6; assert `sensor_sobrepeso` at `remaining`=3 for 10 cycles → `state`=2 and `remaining`=3 throughout.
   - After release, `t_expired` follows 4 cycles later (1 cycle back to RUN + 3 ticks).
5. **Priority and restart:**
   - In RUN, `start_timer` with `t_load`=9 → no reload.
   - `restart_timer` together with `sensor_sobrepeso` → `remaining`=`t_load`, `state`=RUN.
   - `restart_timer` in EXPIRED → RUN with `t_expired`=0 next cycle.
6. **Reset mid-operation and prescaler:**
   - Reset during RUN → all outputs return to reset values next cycle.
   - With the macro defined and DIV=4, `t_load`=3 → `t_expired` at N+13.

Source files
------------

// File: rtl/temporizador_puerta.sv
`default_nettype none
//==============================================================================
// Module   : temporizador_puerta
// Purpose  : Door-dwell timer answering the elevator controller's timer
//            handshake. Loads a programmable interval on start/restart,
//            counts it down one tick at a time and flags expiry. A door
//            obstruction re-arms the count; an overweight condition freezes
//            both the count and the prescaler.
// Config   : `TEMPORIZADOR_PRESCALER_EN defined   -> one tick every DIV clocks
//            `TEMPORIZADOR_PRESCALER_EN undefined -> one tick every clock in
//                                                    RUN, DIV unused
// Ports    : clk, reset          - clock / synchronous active-high reset
//            start_timer         - start from IDLE or EXPIRED
//            restart_timer       - reload and run from any state
//            sensor_puerta       - door obstructed, reloads while running
//            sensor_sobrepeso    - overweight, freezes the count
//            t_load[CNT_W]       - interval in ticks (0 -> DEFAULT_TIME)
//            t_expired, busy     - status flags (registered)
//            remaining[CNT_W]    - ticks left (registered)
//            state[2]            - IDLE=0 RUN=1 HOLD=2 EXPIRED=3
// Revision : 1.0 - initial release
//==============================================================================
module temporizador_puerta #(
    parameter int DIV          = 50000,
    parameter int CNT_W        = 16,
    parameter int DEFAULT_TIME = 3000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_timer,
    input  logic             restart_timer,
    input  logic             sensor_puerta,
    input  logic             sensor_sobrepeso,
    input  logic [CNT_W-1:0] t_load,
    output logic             t_expired,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HOLD    = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_default = CNT_W'(DEFAULT_TIME);

    // A divisor below 2 would make the prescaler degenerate; stop elaboration.
    if (DIV < 2) begin : g_div_check
        $error("temporizador_puerta: DIV must be >= 2");
    end

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_remaining;
    logic             r_t_expired;
    logic             r_busy;
    logic             w_load;      // load interval, clear prescaler
    logic             w_count;     // RUN with no higher-priority event
    logic             w_tick;
    logic [CNT_W-1:0] w_load_val;

    assign w_load_val = (t_load == '0) ? c_default : t_load;

`ifdef TEMPORIZADOR_PRESCALER_EN
    localparam int              c_presc_w   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(DIV - 1);

    logic [c_presc_w-1:0] r_presc;

    assign w_tick = (r_presc == c_presc_max);

    // Prescaler only advances while counting, so HOLD freezes it in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_load) begin
            r_presc <= '0;
        end else if (w_count) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    // Next-state decode; command priority is encoded by the if/else order.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_count      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (restart_timer || start_timer) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (restart_timer) begin
                    w_load = 1'b1;
                end else if (sensor_sobrepeso) begin
                    w_state_next = ST_HOLD;
                end else if (sensor_puerta) begin
                    w_load = 1'b1;
                end else begin
                    w_count = 1'b1;
                    // <= 1 rather than == 1 so the count can never wrap.
                    if (w_tick && (r_remaining <= CNT_W'(1))) begin
                        w_state_next = ST_EXPIRED;
                    end
                end
            end
            ST_HOLD: begin
                if (restart_timer) begin
                    w_load = 1'b1;
                end else if (!sensor_sobrepeso) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_EXPIRED: begin
                if (restart_timer || start_timer) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_t_expired <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_t_expired <= (w_state_next == ST_EXPIRED);
            r_busy      <= (w_state_next == ST_RUN) || (w_state_next == ST_HOLD);
            if (w_load) begin
                r_remaining <= w_load_val;
            end else if (w_count && w_tick) begin
                r_remaining <= (r_remaining <= CNT_W'(1)) ? '0
                                                          : r_remaining - 1'b1;
            end
        end
    end

    assign t_expired = r_t_expired;
    assign busy      = r_busy;
    assign remaining = r_remaining;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_temporizador_puerta.sv
`default_nettype none
//==============================================================================
// Module   : tb_temporizador_puerta
// Purpose  : Directed self-checking bench for temporizador_puerta. Without
//            `TEMPORIZADOR_PRESCALER_EN every RUN cycle is a tick; with it
//            defined only the DIV=4 prescaler scenario is exercised.
// Revision : 1.0 - initial release
//==============================================================================
module tb_temporizador_puerta;

    localparam int DIV          = 4;
    localparam int CNT_W        = 16;
    localparam int DEFAULT_TIME = 3000;

    logic             clk;
    logic             reset;
    logic             start_timer;
    logic             restart_timer;
    logic             sensor_puerta;
    logic             sensor_sobrepeso;
    logic [CNT_W-1:0] t_load;
    logic             t_expired;
    logic             busy;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       state;

    int n_total = 0;
    int n_bad   = 0;

    temporizador_puerta #(
        .DIV          (DIV),
        .CNT_W        (CNT_W),
        .DEFAULT_TIME (DEFAULT_TIME)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .start_timer      (start_timer),
        .restart_timer    (restart_timer),
        .sensor_puerta    (sensor_puerta),
        .sensor_sobrepeso (sensor_sobrepeso),
        .t_load           (t_load),
        .t_expired        (t_expired),
        .busy             (busy),
        .remaining        (remaining),
        .state            (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One active edge, then settle so outputs are sampled away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int st, input int rem,
                           input int exp_f, input int bsy);
        chk({tag, ".state"},     32'(state),     32'(st));
        chk({tag, ".remaining"}, 32'(remaining), 32'(rem));
        chk({tag, ".t_expired"}, 32'(t_expired), 32'(exp_f));
        chk({tag, ".busy"},      32'(busy),      32'(bsy));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        start_timer      = 1'b0;
        restart_timer    = 1'b0;
        sensor_puerta    = 1'b0;
        sensor_sobrepeso = 1'b0;
        t_load           = '0;
        step();
        step();
        reset = 1'b0;
        chk_all("reset", 0, 0, 0, 0);

`ifdef TEMPORIZADOR_PRESCALER_EN
        // DIV=4, load 3: ticks at edges N+4, N+8, N+12; expiry seen at N+13.
        t_load = 16'd3; start_timer = 1'b1;
        step();
        start_timer = 1'b0;
        chk_all("presc_load", 1, 3, 0, 1);
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i < 12) chk("presc_rem", 32'(remaining), 32'(3 - i / 4));
            else        chk_all("presc_exp", 3, 0, 1, 0);
        end
`else
        // Sensors are ignored in IDLE.
        sensor_puerta = 1'b1; sensor_sobrepeso = 1'b1;
        step();
        sensor_puerta = 1'b0; sensor_sobrepeso = 1'b0;
        chk_all("idle_sensors", 0, 0, 0, 0);

        // Basic dwell: 5,4,3,2,1 then expired at N+6.
        t_load = 16'd5; start_timer = 1'b1;
        step();
        start_timer = 1'b0;
        chk_all("dwell_load", 1, 5, 0, 1);
        for (int k = 4; k >= 1; k--) begin
            step();
            chk("dwell_rem", 32'(remaining), 32'(k));
        end
        step();
        chk_all("dwell_exp", 3, 0, 1, 0);
        repeat (3) step();
        chk_all("dwell_hold", 3, 0, 1, 0);

        // Restart from EXPIRED.
        t_load = 16'd7; restart_timer = 1'b1;
        step();
        restart_timer = 1'b0;
        chk_all("restart_exp", 1, 7, 0, 1);

        // start_timer in RUN is ignored; the tick proceeds (7 -> 6).
        t_load = 16'd9; start_timer = 1'b1;
        step();
        start_timer = 1'b0;
        chk_all("start_in_run", 1, 6, 0, 1);

        // restart beats overweight.
        restart_timer = 1'b1; sensor_sobrepeso = 1'b1;
        step();
        restart_timer = 1'b0; sensor_sobrepeso = 1'b0;
        chk_all("restart_vs_ow", 1, 9, 0, 1);

        // Both sensors: HOLD with no reload.
        t_load = 16'd2; sensor_sobrepeso = 1'b1; sensor_puerta = 1'b1;
        step();
        chk_all("both_sensors", 2, 9, 0, 1);
        sensor_sobrepeso = 1'b0; sensor_puerta = 1'b0;
        step();
        chk_all("hold_release", 1, 9, 0, 1);
        step();
        chk("resume_tick", 32'(remaining), 32'd8);

        // Reset mid-count.
        do_reset();
        chk_all("reset_run", 0, 0, 0, 0);

        // Door obstruction at remaining=2 for 3 cycles.
        t_load = 16'd4; start_timer = 1'b1;
        step();
        start_timer = 1'b0;
        step();
        step();
        chk("door_pre", 32'(remaining), 32'd2);
        sensor_puerta = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("door_held", 32'(remaining), 32'd4);
        end
        sensor_puerta = 1'b0;
        for (int k = 3; k >= 1; k--) begin
            step();
            chk("door_count", 32'(remaining), 32'(k));
        end
        step();
        chk_all("door_exp", 3, 0, 1, 0);

        // Overweight freeze at remaining=3 for 10 cycles.
        t_load = 16'd6; start_timer = 1'b1;
        step();
        start_timer = 1'b0;
        repeat (3) step();
        chk("ow_pre", 32'(remaining), 32'd3);
        sensor_sobrepeso = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("ow_state", 32'(state), 32'd2);
            chk("ow_rem", 32'(remaining), 32'd3);
        end
        sensor_sobrepeso = 1'b0;
        step();
        chk_all("ow_back_run", 1, 3, 0, 1);
        step();
        chk("ow_tick1", 32'(remaining), 32'd2);
        step();
        chk("ow_tick2", 32'(remaining), 32'd1);
        step();
        chk_all("ow_exp", 3, 0, 1, 0);

        // Default load: t_load=0 -> 3000, expiry at N+3001.
        t_load = 16'd0; start_timer = 1'b1;
        step();
        start_timer = 1'b0;
        chk_all("def_load", 1, DEFAULT_TIME, 0, 1);
        repeat (DEFAULT_TIME - 1) step();
        chk_all("def_last", 1, 1, 0, 1);
        step();
        chk_all("def_exp", 3, 0, 1, 0);

        // Reset from EXPIRED.
        do_reset();
        chk_all("reset_exp", 0, 0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
